keccak_sponge_io: RTL and testbench



---
 rtl/keccak_sponge_io.sv | 142 ++++++++++++++
 tb/tb_keccak_sponge_io.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_sponge_io.sv
// Sponge-side responder for the Keccak accelerator stream.
// The block absorbs 64-bit lanes into a 1600-bit state.
// It hands the state to an external Keccak-f[1600] round core.
// After the last block it squeezes OUT_LANES lanes back out.
module keccak_sponge_io #(
    parameter int RATE_LANES = 21,
    parameter int OUT_LANES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [63:0]   din,
    input  logic          din_valid,
    output logic          buffer_full,
    input  logic          last_block,
    output logic          ready,
    output logic [63:0]   dout,
    output logic          dout_valid,
    output logic          perm_start,
    input  logic          perm_done,
    output logic [1599:0] perm_state_o,
    input  logic [1599:0] perm_state_i
);

    typedef enum logic [1:0] {
        ST_ABSORB  = 2'd0,
        ST_PERMUTE = 2'd1,
        ST_SQUEEZE = 2'd2
    } state_t;

    localparam logic [4:0] LC_FULL = 5'(RATE_LANES);
    localparam logic [4:0] SQ_LAST = 5'(OUT_LANES - 1);

    state_t         r_fsm;
    state_t         w_fsm_nxt;
    logic [1599:0]  r_state;
    logic [4:0]     r_lane_cnt;
    logic [4:0]     r_sq_cnt;
    logic           r_last_q;
    // High exactly during the first PERMUTE cycle.
    // It also masks perm_done for that cycle.
    logic           r_perm_start;

    logic           w_full;
    logic           w_lane_acc;
    logic           w_start_acc;
    logic           w_done_acc;
    logic           w_sq_last;
    logic [10:0]    w_lane_ofs;
    logic [10:0]    w_sq_ofs;

    assign w_full     = (r_lane_cnt == LC_FULL);
    assign w_lane_ofs = {r_lane_cnt, 6'd0};
    assign w_sq_ofs   = {r_sq_cnt, 6'd0};

    // Outputs come from registers only.
    // There is no input-to-output path.
    assign buffer_full  = w_full;
    assign ready        = (r_fsm == ST_ABSORB);
    assign dout_valid   = (r_fsm == ST_SQUEEZE);
    assign dout         = r_state[w_sq_ofs +: 64];
    assign perm_start   = r_perm_start;
    assign perm_state_o = r_state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_fsm <= ST_ABSORB;
        else        r_fsm <= w_fsm_nxt;
    end

    // Next-state logic and the per-cycle accept strobes
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_lane_acc  = 1'b0;
        w_start_acc = 1'b0;
        w_done_acc  = 1'b0;
        w_sq_last   = 1'b0;
        case (r_fsm)
            ST_ABSORB: begin
                // A start is judged against the registered count.
                // So a lane that only now fills the buffer cannot also launch the permutation.
                w_lane_acc = din_valid && !w_full;
                if (start && w_full) begin
                    w_start_acc = 1'b1;
                    w_fsm_nxt   = ST_PERMUTE;
                end
            end
            ST_PERMUTE: begin
                if (perm_done && !r_perm_start) begin
                    w_done_acc = 1'b1;
                    w_fsm_nxt  = r_last_q ? ST_SQUEEZE : ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (r_sq_cnt == SQ_LAST) begin
                    w_sq_last = 1'b1;
                    w_fsm_nxt = ST_ABSORB;
                end
            end
            default: w_fsm_nxt = ST_ABSORB;
        endcase
    end

    // Keccak state
    // Three update sources: absorb XOR, permutation load, and post-squeeze clear.
    always_ff @(posedge clk) begin
        if (!rst_n)          r_state <= '0;
        else if (w_done_acc) r_state <= perm_state_i;
        else if (w_sq_last)  r_state <= '0;
        else if (w_lane_acc) r_state[w_lane_ofs +: 64] <= r_state[w_lane_ofs +: 64] ^ din;
    end

    // Absorb lane counter
    // It saturates at RATE_LANES because accepts stop once full.
    always_ff @(posedge clk) begin
        if (!rst_n)                      r_lane_cnt <= '0;
        else if (w_done_acc || w_sq_last) r_lane_cnt <= '0;
        else if (w_lane_acc)             r_lane_cnt <= r_lane_cnt + 5'd1;
    end

    // Squeeze lane counter
    always_ff @(posedge clk) begin
        if (!rst_n)                    r_sq_cnt <= '0;
        else if (w_done_acc)           r_sq_cnt <= '0;
        else if (w_sq_last)            r_sq_cnt <= '0;
        else if (r_fsm == ST_SQUEEZE)  r_sq_cnt <= r_sq_cnt + 5'd1;
    end

    // Remember whether this permutation is followed by a squeeze
    always_ff @(posedge clk) begin
        if (!rst_n)           r_last_q <= 1'b0;
        else if (w_start_acc) r_last_q <= last_block;
        else if (w_sq_last)   r_last_q <= 1'b0;
    end

    // One-cycle launch pulse to the round core
    always_ff @(posedge clk) begin
        if (!rst_n) r_perm_start <= 1'b0;
        else        r_perm_start <= w_start_acc;
    end

endmodule

// File: tb/tb_keccak_sponge_io.sv
// Directed and randomized bench for keccak_sponge_io.
// The reference model keeps the state as 25 plain lanes plus a fill count.
module tb_keccak_sponge_io;
    localparam int RL = 21;
    localparam int OL = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, din_valid, last_block, perm_done;
    logic [63:0]   din;
    logic [1599:0] perm_state_i;
    logic          buffer_full, ready, dout_valid, perm_start;
    logic [63:0]   dout;
    logic [1599:0] perm_state_o;

    // Second build: RATE_LANES=17, OUT_LANES=1
    logic          b_start, b_din_valid, b_last_block, b_perm_done;
    logic [63:0]   b_din;
    logic [1599:0] b_perm_state_i;
    logic          b_buffer_full, b_ready, b_dout_valid, b_perm_start;
    logic [63:0]   b_dout;
    logic [1599:0] b_perm_state_o;

    int total = 0;
    int bad = 0;

    logic [63:0] m [25];
    int          mcnt;
    logic [63:0] sq_out [OL];

    always #5 clk = ~clk;

    keccak_sponge_io #(.RATE_LANES(RL), .OUT_LANES(OL)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .buffer_full(buffer_full), .last_block(last_block), .ready(ready),
        .dout(dout), .dout_valid(dout_valid), .perm_start(perm_start),
        .perm_done(perm_done), .perm_state_o(perm_state_o), .perm_state_i(perm_state_i)
    );

    keccak_sponge_io #(.RATE_LANES(17), .OUT_LANES(1)) u_dut17 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .din(b_din), .din_valid(b_din_valid),
        .buffer_full(b_buffer_full), .last_block(b_last_block), .ready(b_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .perm_start(b_perm_start),
        .perm_done(b_perm_done), .perm_state_o(b_perm_state_o), .perm_state_i(b_perm_state_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed lane0=%h expected lane0=%h", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [1599:0] r1600();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [1599:0] pack();
        logic [1599:0] p;
        for (int i = 0; i < 25; i++) p[64*i +: 64] = m[i];
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 25; i++) m[i] = '0;
        mcnt = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_ready"}, ready, 1'b1);
        chk1({tag, "_full"}, buffer_full, 1'b0);
        chk1({tag, "_dvalid"}, dout_valid, 1'b0);
        chk1({tag, "_pstart"}, perm_start, 1'b0);
        chk({tag, "_dout"}, dout, 64'h0);
        chk_st({tag, "_state"}, perm_state_o, '0);
    endtask

    // Offer one lane. The model drops it once the block already holds RL lanes.
    task automatic send(input logic [63:0] d);
        din = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        if (mcnt < RL) begin
            m[mcnt] = m[mcnt] ^ d;
            mcnt++;
        end
        chk1("buffer_full", buffer_full, mcnt == RL);
        chk_st("absorb_state", perm_state_o, pack());
    endtask

    // The core answers dly edges after the perm_start edge with the state XOR mask.
    // When early is set, perm_done is also held high in the perm_start cycle.
    task automatic permute(input logic last, input logic [1599:0] mask, input int dly, input logic early);
        logic [1599:0] nxt;
        start = 1'b1;
        last_block = last;
        tick();
        start = 1'b0;
        last_block = 1'b0;
        chk1("perm_start_pulse", perm_start, 1'b1);
        chk1("ready_in_permute", ready, 1'b0);
        if (early) begin
            perm_done = 1'b1;
            perm_state_i = ~pack();
        end
        tick();
        perm_done = 1'b0;
        chk1("perm_start_fall", perm_start, 1'b0);
        chk_st("state_held", perm_state_o, pack());
        nxt = pack() ^ mask;
        for (int i = 2; i < dly; i++) tick();
        chk_st("state_before_done", perm_state_o, pack());
        perm_state_i = nxt;
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        for (int i = 0; i < 25; i++) m[i] = nxt[64*i +: 64];
        mcnt = 0;
        chk_st("perm_load", perm_state_o, nxt);
        chk1("full_after_perm", buffer_full, 1'b0);
        if (last) begin
            for (int j = 0; j < OL; j++) begin
                chk1("squeeze_valid", dout_valid, 1'b1);
                chk1("squeeze_ready", ready, 1'b0);
                chk("squeeze_dout", dout, m[j]);
                sq_out[j] = dout;
                tick();
            end
            chk1("squeeze_end_valid", dout_valid, 1'b0);
            chk1("squeeze_end_ready", ready, 1'b1);
            chk_st("squeeze_end_state", perm_state_o, '0);
            model_clear();
        end else begin
            chk1("next_block_ready", ready, 1'b1);
            chk1("next_block_valid", dout_valid, 1'b0);
        end
    endtask

    initial begin
        logic [63:0]   l0;
        logic [1599:0] mask;
        logic [63:0]   bl [17];
        int            nvalid;

        rst_n = 1'b0; start = 1'b0; din = '0; din_valid = 1'b0; last_block = 1'b0;
        perm_done = 1'b0; perm_state_i = '0;
        b_start = 1'b0; b_din = '0; b_din_valid = 1'b0; b_last_block = 1'b0;
        b_perm_done = 1'b0; b_perm_state_i = '0;
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset("reset");

        // Single block with a directed ramp. The core inverts every bit.
        for (int i = 1; i <= RL; i++) send(64'(i));
        permute(1'b1, {1600{1'b1}}, 3, 1'b0);
        for (int j = 0; j < OL; j++) chk("single_block_dout", sq_out[j], ~64'(j + 1));

        // Two blocks with an identity core on the first block
        for (int i = 0; i < RL; i++) send(r64());
        l0 = m[0];
        permute(1'b0, '0, 3, 1'b0);
        for (int i = 0; i < RL; i++) send(64'hFF);
        permute(1'b1, '0, 4, 1'b0);
        chk("two_block_lane0", sq_out[0], l0 ^ 64'hFF);

        // Early start coincides with the 21st lane, then a 22nd lane overflows
        for (int i = 0; i < RL - 1; i++) send(r64());
        din = r64();
        din_valid = 1'b1;
        start = 1'b1;
        last_block = 1'b1;
        tick();
        m[mcnt] = m[mcnt] ^ din;
        mcnt++;
        din_valid = 1'b0;
        start = 1'b0;
        last_block = 1'b0;
        chk1("early_start_full", buffer_full, 1'b1);
        chk1("early_start_no_pulse", perm_start, 1'b0);
        chk1("early_start_ready", ready, 1'b1);
        tick();
        chk1("early_start_no_pulse2", perm_start, 1'b0);
        send(r64());
        permute(1'b1, r1600(), 3, 1'b0);

        // perm_done is high in the perm_start cycle and must be ignored there
        for (int i = 0; i < RL; i++) send(r64());
        permute(1'b1, r1600(), 5, 1'b1);

        // Reset mid-PERMUTE; a late perm_done must be ignored
        for (int i = 0; i < RL; i++) send(r64());
        start = 1'b1;
        last_block = 1'b1;
        tick();
        start = 1'b0;
        last_block = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk_reset("rst_permute");
        perm_state_i = r1600();
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        chk_reset("late_done");
        for (int i = 0; i < RL; i++) send(r64());
        permute(1'b1, r1600(), 3, 1'b0);

        // Reset mid-SQUEEZE
        for (int i = 0; i < RL; i++) send(r64());
        mask = r1600();
        start = 1'b1;
        last_block = 1'b1;
        tick();
        start = 1'b0;
        last_block = 1'b0;
        tick();
        perm_state_i = pack() ^ mask;
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        chk1("sq_before_reset", dout_valid, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk_reset("rst_squeeze");
        for (int i = 0; i < RL; i++) send(r64());
        permute(1'b1, r1600(), 3, 1'b0);

        // RATE_LANES=17, OUT_LANES=1 build
        for (int i = 0; i < 17; i++) begin
            bl[i] = r64();
            b_din = bl[i];
            b_din_valid = 1'b1;
            tick();
            chk1("b17_full", b_buffer_full, i == 16);
        end
        b_din_valid = 1'b0;
        for (int i = 0; i < 17; i++) chk("b17_absorb_lane", b_perm_state_o[64*i +: 64], bl[i]);
        b_start = 1'b1;
        b_last_block = 1'b1;
        tick();
        b_start = 1'b0;
        b_last_block = 1'b0;
        chk1("b17_perm_start", b_perm_start, 1'b1);
        tick();
        mask = r1600();
        b_perm_state_i = mask;
        b_perm_done = 1'b1;
        tick();
        b_perm_done = 1'b0;
        chk("b17_dout", b_dout, mask[63:0]);
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            if (b_dout_valid) nvalid++;
            tick();
        end
        chk("b17_valid_cycles", 64'(nvalid), 64'd1);
        chk1("b17_ready_after", b_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
